mouse_cursor_overlay: RTL
=========================

MOUSE_CURSOR_OVERLAY -- requirements
Module: mouse_cursor_overlay

Interface
REQ-001 Parameter H_RES, default 640: visible width in pixels.
REQ-002 Parameter V_RES, default 480: visible height in pixels.
REQ-003 Parameter COLOR_BITS, default 4: bits per colour channel.
REQ-004 Parameter CURSOR_SIZE, default 8: cursor side length in pixels; legal range is 2..64.
REQ-005 Parameter SENS_SHIFT, default 0: motion gain as a left shift of the delta; legal range is 0..2.
REQ-006 Parameter CURSOR_SHAPE, default 0: 0 selects a filled square, 1 selects a crosshair.
REQ-007 Port list, one per line:
- Clk  in  1  system clock; one clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- MouseValid  in  1  single-cycle strobe marking a new movement packet.
- MouseDx  in  9  signed two's-complement X delta; positive is right.
- MouseDy  in  9  signed two's-complement Y delta; positive is up.
- MouseButtons  in  3  button state: [0] left, [1] right, [2] middle.
- PixelTick  in  1  pixel enable from the VGA timing block.
- VgaOn  in  1  high in the visible area.
- PixelX  in  10  current pixel column.
- PixelY  in  10  current pixel row.
- BgRGB  in  3*COLOR_BITS  background pixel, ordered {R,G,B}.
- RGB  out  3*COLOR_BITS  composited pixel, ordered {R,G,B}.
- PosX  out  10  live cursor X position.
- PosY  out  10  live cursor Y position.

Function
REQ-008 On MouseValid, the block shall sign-extend MouseDx and MouseDy to 13 bits, then shift each left by SENS_SHIFT.
REQ-009 On MouseValid, PosX shall be set to clamp(PosX + dx, 0, H_RES-1) in the next cycle.
REQ-010 On MouseValid, PosY shall be set to clamp(PosY - dy, 0, V_RES-1) in the next cycle; the Y axis is inverted.
REQ-011 Clamping shall saturate at both edges and never wrap.
REQ-012 When MouseValid is low, PosX and PosY shall hold their values.
REQ-013 When PixelTick is high with PixelX==0 and PixelY==0, the block shall copy PosX, PosY and MouseButtons into frame shadow registers.
REQ-014 If MouseValid and the frame latch occur in the same cycle, the shadow registers shall capture the pre-update position, so the update appears in the next frame.
REQ-015 Pixel offsets shall be computed as ox = PixelX - shadowX and oy = PixelY - shadowY, unsigned.
REQ-016 A pixel is a cursor pixel when ox < CURSOR_SIZE and oy < CURSOR_SIZE and one of the following holds:
- CURSOR_SHAPE==0; or
- CURSOR_SHAPE==1 and (ox == CURSOR_SIZE/2 or oy == CURSOR_SIZE/2).
REQ-017 The cursor shall be clipped silently at the right and bottom screen edges.
REQ-018 Cursor colour shall be chosen from the shadowed buttons, first match wins:
- left pressed: full red;
- else right pressed: full green;
- else middle pressed: full blue;
- else: full white.
REQ-019 RGB shall be registered and update only on cycles where PixelTick is high, with 1 Clk latency from PixelTick.
REQ-020 On an update cycle, RGB shall be 0 when VgaOn is low, the cursor colour on a cursor pixel, and BgRGB otherwise.

Reset
REQ-021 While Reset is low:
- PosX shall be H_RES/2 and PosY shall be V_RES/2;
- the shadow registers shall be H_RES/2, V_RES/2 and buttons 0;
- RGB shall be 0.
REQ-022 Reset asserted mid-frame shall take effect immediately.
REQ-023 After Reset releases, the cursor shall render at centre until the next frame latch.

Structure
REQ-024 Package mouse_pkg shall hold:
- button bit indices;
- cursor shape codes;
- default resolution constants;
- the delta width of 9 and the accumulator width of 13.
REQ-025 Sub-module cursor_axis_clamp (parameters MAX, SENS_SHIFT) shall perform the per-axis accumulate and saturate, and shall be instantiated twice, the Y instance with a negated delta.

Verification
REQ-026 Reset then release -> PosX=320, PosY=240, and RGB=0 while VgaOn is low.
REQ-027 From PosX=320, apply MouseValid with Dx=+255 then Dx=+255 -> PosX=575, then PosX=639 (clamped).
REQ-028 From PosY=240, apply MouseValid with Dy=-256 (down) -> PosY=479, clamped, not wrapped.
REQ-029 Cursor at (100,50), left button pressed, frame latched -> RGB=0xF00 at pixel (103,53), and RGB=BgRGB at (108,53).
REQ-030 Apply MouseValid with Dx=+10 in the same cycle as the frame latch -> the current frame draws the cursor at the old X, and the next frame draws it at old X+10.
REQ-031 CURSOR_SHAPE=1, cursor at (0,0), no buttons pressed -> RGB=0xFFF at (4,1), and RGB=BgRGB at (1,1).

Source files
------------

// File: rtl/mouse_cursor_overlay_pkg.sv
// Shared constants and types for the mouse cursor overlay.
package mouse_pkg;

    // Bit positions within MouseButtons
    localparam int unsigned BTN_LEFT   = 0;
    localparam int unsigned BTN_RIGHT  = 1;
    localparam int unsigned BTN_MIDDLE = 2;
    localparam int unsigned BTN_W      = 3;

    // Cursor shape codes
    typedef enum logic {
        SHAPE_SQUARE = 1'b0,
        SHAPE_CROSS  = 1'b1
    } cursor_shape_e;

    // Default visible resolution
    localparam int unsigned DEF_H_RES = 640;
    localparam int unsigned DEF_V_RES = 480;

    // Raw packet delta width, signed accumulator width, screen coordinate width
    localparam int unsigned DELTA_W = 9;
    localparam int unsigned ACC_W   = 13;
    localparam int unsigned POS_W   = 10;

    typedef logic signed [ACC_W-1:0] acc_t;

    // Sign-extend a raw packet delta into the accumulator width
    function automatic acc_t sext_delta(input logic [DELTA_W-1:0] d);
        return acc_t'($signed(d));
    endfunction

endpackage

// File: rtl/mouse_cursor_overlay_if.sv
// Bundle of mouse-packet, pixel-stream and composited-output signals.
interface mouse_cursor_overlay_if
    import mouse_pkg::*;
#(
    parameter int unsigned COLOR_BITS = 4
);
    logic                    MouseValid;
    logic [DELTA_W-1:0]      MouseDx;
    logic [DELTA_W-1:0]      MouseDy;
    logic [BTN_W-1:0]        MouseButtons;
    logic                    PixelTick;
    logic                    VgaOn;
    logic [POS_W-1:0]        PixelX;
    logic [POS_W-1:0]        PixelY;
    logic [3*COLOR_BITS-1:0] BgRGB;
    logic [3*COLOR_BITS-1:0] RGB;
    logic [POS_W-1:0]        PosX;
    logic [POS_W-1:0]        PosY;

    // Source of mouse packets and pixel stream; sink of the composited pixel
    modport master (
        output MouseValid, MouseDx, MouseDy, MouseButtons,
        output PixelTick, VgaOn, PixelX, PixelY, BgRGB,
        input  RGB, PosX, PosY
    );

    // The overlay itself
    modport slave (
        input  MouseValid, MouseDx, MouseDy, MouseButtons,
        input  PixelTick, VgaOn, PixelX, PixelY, BgRGB,
        output RGB, PosX, PosY
    );
endinterface

// File: rtl/mouse_cursor_overlay_cursor_axis_clamp.sv
// One cursor axis: accumulate a scaled signed delta and saturate to 0..MAX.
module cursor_axis_clamp
    import mouse_pkg::*;
#(
    parameter int unsigned MAX        = DEF_H_RES - 1,
    parameter int unsigned SENS_SHIFT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid,
    input  acc_t             delta,
    output logic [POS_W-1:0] pos
);
    localparam logic [POS_W-1:0]        RESET_POS = POS_W'((MAX + 1) / 2);
    localparam logic [POS_W-1:0]        MAX_POS   = POS_W'(MAX);
    localparam logic signed [ACC_W:0]   MAX_S     = (ACC_W + 1)'(MAX);

    logic [POS_W-1:0]      pos_d, pos_q;
    acc_t                  gain;
    logic signed [ACC_W:0] sum;

    // Next position: one guard bit above the accumulator so neither edge can wrap
    always_comb begin
        gain  = acc_t'(delta <<< SENS_SHIFT);
        sum   = $signed({{(ACC_W + 1 - POS_W){1'b0}}, pos_q}) + (ACC_W + 1)'(gain);
        pos_d = pos_q;
        if (valid) begin
            if (sum < 0)
                pos_d = '0;
            else if (sum > MAX_S)
                pos_d = MAX_POS;
            else
                pos_d = sum[POS_W-1:0];
        end
    end

    // Position register, centred on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pos_q <= RESET_POS;
        else
            pos_q <= pos_d;
    end

    assign pos = pos_q;
endmodule

// File: rtl/mouse_cursor_overlay.sv
// Mouse-driven cursor position tracking and per-pixel cursor compositing.
module mouse_cursor_overlay
    import mouse_pkg::*;
#(
    parameter int unsigned H_RES        = DEF_H_RES,
    parameter int unsigned V_RES        = DEF_V_RES,
    parameter int unsigned COLOR_BITS   = 4,
    parameter int unsigned CURSOR_SIZE  = 8,
    parameter int unsigned SENS_SHIFT   = 0,
    parameter int unsigned CURSOR_SHAPE = 0
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    MouseValid,
    input  logic [DELTA_W-1:0]      MouseDx,
    input  logic [DELTA_W-1:0]      MouseDy,
    input  logic [BTN_W-1:0]        MouseButtons,
    input  logic                    PixelTick,
    input  logic                    VgaOn,
    input  logic [POS_W-1:0]        PixelX,
    input  logic [POS_W-1:0]        PixelY,
    input  logic [3*COLOR_BITS-1:0] BgRGB,
    output logic [3*COLOR_BITS-1:0] RGB,
    output logic [POS_W-1:0]        PosX,
    output logic [POS_W-1:0]        PosY
);
    localparam cursor_shape_e      SHAPE  = cursor_shape_e'(CURSOR_SHAPE[0]);
    localparam logic [POS_W:0]     CSZ    = (POS_W + 1)'(CURSOR_SIZE);
    localparam logic [POS_W-1:0]   HALF   = POS_W'(CURSOR_SIZE / 2);
    localparam logic [COLOR_BITS-1:0] FULL = '1;
    localparam logic [COLOR_BITS-1:0] NONE = '0;

    acc_t                    dx_ext, dy_neg;
    logic [POS_W-1:0]        sx_d, sx_q, sy_d, sy_q;
    logic [BTN_W-1:0]        sbtn_d, sbtn_q;
    logic                    frame_latch;
    logic [POS_W-1:0]        ox, oy;
    logic                    in_box, on_shape;
    logic [3*COLOR_BITS-1:0] cursor_rgb;
    logic [3*COLOR_BITS-1:0] rgb_d, rgb_q;

    // Packet deltas; screen Y grows downward, so the Y delta is negated
    always_comb begin
        dx_ext = sext_delta(MouseDx);
        dy_neg = -sext_delta(MouseDy);
    end

    cursor_axis_clamp #(
        .MAX        (H_RES - 1),
        .SENS_SHIFT (SENS_SHIFT)
    ) u_x_axis (
        .clk   (Clk),
        .rst_n (Reset),
        .valid (MouseValid),
        .delta (dx_ext),
        .pos   (PosX)
    );

    cursor_axis_clamp #(
        .MAX        (V_RES - 1),
        .SENS_SHIFT (SENS_SHIFT)
    ) u_y_axis (
        .clk   (Clk),
        .rst_n (Reset),
        .valid (MouseValid),
        .delta (dy_neg),
        .pos   (PosY)
    );

    // Frame shadow capture at the first pixel; the live position is still pre-update here
    always_comb begin
        frame_latch = PixelTick && (PixelX == '0) && (PixelY == '0);
        sx_d        = sx_q;
        sy_d        = sy_q;
        sbtn_d      = sbtn_q;
        if (frame_latch) begin
            sx_d   = PosX;
            sy_d   = PosY;
            sbtn_d = MouseButtons;
        end
    end

    // Cursor hit test and colour; unsigned offsets wrap large left/above the cursor
    always_comb begin
        ox       = PixelX - sx_q;
        oy       = PixelY - sy_q;
        in_box   = ({1'b0, ox} < CSZ) && ({1'b0, oy} < CSZ);
        on_shape = (SHAPE == SHAPE_CROSS) ? ((ox == HALF) || (oy == HALF)) : 1'b1;
        if (sbtn_q[BTN_LEFT])
            cursor_rgb = {FULL, NONE, NONE};
        else if (sbtn_q[BTN_RIGHT])
            cursor_rgb = {NONE, FULL, NONE};
        else if (sbtn_q[BTN_MIDDLE])
            cursor_rgb = {NONE, NONE, FULL};
        else
            cursor_rgb = {FULL, FULL, FULL};
    end

    // Composited pixel, updated only on pixel ticks
    always_comb begin
        rgb_d = rgb_q;
        if (PixelTick) begin
            if (!VgaOn)
                rgb_d = '0;
            else if (in_box && on_shape)
                rgb_d = cursor_rgb;
            else
                rgb_d = BgRGB;
        end
    end

    // Shadow and output registers
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            sx_q   <= POS_W'(H_RES / 2);
            sy_q   <= POS_W'(V_RES / 2);
            sbtn_q <= '0;
            rgb_q  <= '0;
        end else begin
            sx_q   <= sx_d;
            sy_q   <= sy_d;
            sbtn_q <= sbtn_d;
            rgb_q  <= rgb_d;
        end
    end

    assign RGB = rgb_q;
endmodule
